// File: rtl/ext_bus_responder.sv
// External-side SM83 data bus responder: windowed byte array
// serviced through read/write strobes with programmable wait states.
module ext_bus_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF80,
    parameter int          SIZE_LOG2   = 7,
    parameter int          WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic        RD,
    input  logic        WR,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic        HIT,
    output logic        BUSY,
    output logic        ERR
);

    localparam int         DEPTH = 1 << SIZE_LOG2;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_RD = 3'd1;
    localparam logic [2:0] WAIT_WR = 3'd2;
    localparam logic [2:0] DRIVE   = 3'd3;
    localparam logic [2:0] HOLD    = 3'd4;
    localparam logic [2:0] RECOVER = 3'd5;

    logic [7:0]           mem [DEPTH];
    logic [2:0]           state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [SIZE_LOG2-1:0] areg, areg_nxt;
    logic                 we;
    logic                 err_set;

    assign HIT = (A[15:SIZE_LOG2] == BASE_ADDR[15:SIZE_LOG2]);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        areg_nxt  = areg;
        we        = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                unique case (1'b1)
                    RD && WR: err_set = 1'b1;
                    RD && !WR && HIT: begin
                        areg_nxt = A[SIZE_LOG2-1:0];
                        if (WS == 4'd0) begin
                            state_nxt = DRIVE;
                        end else begin
                            state_nxt = WAIT_RD;
                            cnt_nxt   = WS;
                        end
                    end
                    WR && !RD && HIT: begin
                        areg_nxt = A[SIZE_LOG2-1:0];
                        if (WS == 4'd0) begin
                            we        = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            state_nxt = WAIT_WR;
                            cnt_nxt   = WS;
                        end
                    end
                    default: ;
                endcase
            end
            WAIT_RD: begin
                if (!RD) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd1) begin
                    state_nxt = DRIVE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WAIT_WR: begin
                if (!WR) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd1) begin
                    we        = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DRIVE: begin
                // A write strobe while we drive the bus is a collision
                if (WR) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else if (!RD) begin
                    state_nxt = RECOVER;
                end
            end
            HOLD: begin
                if (!WR) state_nxt = IDLE;
            end
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= 4'd0;
            areg  <= '0;
            D_out <= 8'h00;
            D_oe  <= 1'b0;
            BUSY  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            areg  <= areg_nxt;
            D_oe  <= (state_nxt == DRIVE);
            BUSY  <= (state_nxt == WAIT_RD) || (state_nxt == WAIT_WR);
            ERR   <= ERR | err_set;
            if (state_nxt == DRIVE) D_out <= mem[areg_nxt];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && we) mem[areg_nxt] <= D_in;
    end

endmodule

// File: tb/tb_ext_bus_responder.sv
// Directed bench for ext_bus_responder with wait states 1, 2 and 3
// sharing one stimulus bus; each phase checks the instance it targets.
module tb_ext_bus_responder;

    logic        CLK;
    logic        RESET;
    logic [15:0] A;
    logic        RD;
    logic        WR;
    logic [7:0]  D_in;

    logic [7:0] dout1, dout2, dout3;
    logic       doe1, doe2, doe3;
    logic       hit1, hit2, hit3;
    logic       busy1, busy2, busy3;
    logic       err1, err2, err3;

    int n_checks = 0;
    int n_errors = 0;

    ext_bus_responder #(.BASE_ADDR(16'hFF80), .SIZE_LOG2(7), .WAIT_STATES(1)) u_ws1 (
        .CLK(CLK), .RESET(RESET), .A(A), .RD(RD), .WR(WR), .D_in(D_in),
        .D_out(dout1), .D_oe(doe1), .HIT(hit1), .BUSY(busy1), .ERR(err1)
    );

    ext_bus_responder #(.BASE_ADDR(16'hFF80), .SIZE_LOG2(7), .WAIT_STATES(2)) u_ws2 (
        .CLK(CLK), .RESET(RESET), .A(A), .RD(RD), .WR(WR), .D_in(D_in),
        .D_out(dout2), .D_oe(doe2), .HIT(hit2), .BUSY(busy2), .ERR(err2)
    );

    ext_bus_responder #(.BASE_ADDR(16'hFF80), .SIZE_LOG2(7), .WAIT_STATES(3)) u_ws3 (
        .CLK(CLK), .RESET(RESET), .A(A), .RD(RD), .WR(WR), .D_in(D_in),
        .D_out(dout3), .D_oe(doe3), .HIT(hit3), .BUSY(busy3), .ERR(err3)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        RD    = 1'b0;
        WR    = 1'b0;
        step();
        step();
        RESET = 1'b0;
        step();
    endtask

    // Long enough for every instance to complete the write
    task automatic wr_op(input logic [15:0] addr, input logic [7:0] data);
        A    = addr;
        D_in = data;
        WR   = 1'b1;
        repeat (5) step();
        WR = 1'b0;
        step();
    endtask

    // mask bit0 = ws1, bit1 = ws2, bit2 = ws3
    task automatic rd_chk(input string tag, input logic [15:0] addr,
                          input logic [7:0] exp, input logic [2:0] mask);
        A  = addr;
        RD = 1'b1;
        repeat (5) step();
        if (mask[0]) begin
            check({tag, "_oe1"}, 16'(doe1), 16'h1);
            check({tag, "_d1"}, 16'(dout1), 16'(exp));
        end
        if (mask[1]) begin
            check({tag, "_oe2"}, 16'(doe2), 16'h1);
            check({tag, "_d2"}, 16'(dout2), 16'(exp));
        end
        if (mask[2]) begin
            check({tag, "_oe3"}, 16'(doe3), 16'h1);
            check({tag, "_d3"}, 16'(dout3), 16'(exp));
        end
        RD = 1'b0;
        step();
        step();
    endtask

    initial begin
        RESET = 1'b1;
        RD    = 1'b1;
        WR    = 1'b0;
        A     = 16'hFF80;
        D_in  = 8'h00;

        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_oe", 16'(doe1), 16'h0);
            check("rst_busy", 16'(busy1), 16'h0);
            check("rst_err", 16'(err1), 16'h0);
            check("rst_dout", 16'(dout1), 16'h00);
        end
        RESET = 1'b0;
        RD    = 1'b0;
        step();

        wr_op(16'hFF80, 8'h11);

        // write A5 to FF85 with WR held for 3 edges
        A    = 16'hFF85;
        D_in = 8'hA5;
        WR   = 1'b1;
        step();
        check("wr_busy_e1", 16'(busy1), 16'h1);
        step();
        check("wr_busy_e2", 16'(busy1), 16'h0);
        step();
        check("wr_busy_e3", 16'(busy1), 16'h0);
        WR = 1'b0;
        step();

        RD = 1'b1;
        step();
        check("rd_oe_acc", 16'(doe1), 16'h0);
        step();
        check("rd_oe_lat", 16'(doe1), 16'h1);
        check("rd_d_lat", 16'(dout1), 16'h00A5);
        A = 16'hFF80;
        step();
        check("rd_oe_hold", 16'(doe1), 16'h1);
        check("rd_d_hold", 16'(dout1), 16'h00A5);
        RD = 1'b0;
        step();
        check("rd_oe_fall", 16'(doe1), 16'h0);
        step();

        // out-of-window writes
        A    = 16'hFF7F;
        D_in = 8'hEE;
        WR   = 1'b1;
        #1;
        check("miss_hit_ff7f", 16'(hit1), 16'h0);
        step();
        check("miss_busy_ff7f", 16'(busy1), 16'h0);
        A = 16'h0000;
        #1;
        check("miss_hit_0000", 16'(hit1), 16'h0);
        step();
        check("miss_busy_0000", 16'(busy1), 16'h0);
        WR = 1'b0;
        step();
        rd_chk("miss_keep", 16'hFF85, 8'hA5, 3'b001);

        A = 16'hFFFF;
        #1;
        check("hit_ffff", 16'(hit1), 16'h1);
        wr_op(16'hFFFF, 8'h3C);
        rd_chk("top_rd", 16'hFFFF, 8'h3C, 3'b111);
        rd_chk("base_rd", 16'hFF80, 8'h11, 3'b111);

        // read abort on ws3
        A  = 16'hFF80;
        RD = 1'b1;
        step();
        check("ab_rd_busy1", 16'(busy3), 16'h1);
        check("ab_rd_oe1", 16'(doe3), 16'h0);
        step();
        check("ab_rd_busy2", 16'(busy3), 16'h1);
        check("ab_rd_oe2", 16'(doe3), 16'h0);
        RD = 1'b0;
        step();
        check("ab_rd_busy3", 16'(busy3), 16'h0);
        check("ab_rd_oe3", 16'(doe3), 16'h0);
        step();
        check("ab_rd_oe4", 16'(doe3), 16'h0);
        step();

        // write abort on ws3
        D_in = 8'h99;
        WR   = 1'b1;
        step();
        step();
        WR = 1'b0;
        step();
        check("ab_wr_busy", 16'(busy3), 16'h0);
        step();
        rd_chk("ab_wr_keep", 16'hFF80, 8'h11, 3'b100);

        // collision on ws1
        do_reset();
        A  = 16'hFF85;
        RD = 1'b1;
        step();
        step();
        check("col_drive", 16'(doe1), 16'h1);
        WR = 1'b1;
        step();
        check("col_err", 16'(err1), 16'h1);
        check("col_oe", 16'(doe1), 16'h0);
        RD = 1'b0;
        WR = 1'b0;
        step();
        wr_op(16'hFF90, 8'h77);
        rd_chk("col_after", 16'hFF90, 8'h77, 3'b001);
        check("col_sticky", 16'(err1), 16'h1);

        do_reset();
        check("err_cleared", 16'(err1), 16'h0);
        A    = 16'hFF90;
        D_in = 8'h00;
        RD   = 1'b1;
        WR   = 1'b1;
        step();
        check("rdwr_err", 16'(err1), 16'h1);
        check("rdwr_busy", 16'(busy1), 16'h0);
        check("rdwr_oe", 16'(doe1), 16'h0);
        RD = 1'b0;
        WR = 1'b0;
        step();
        rd_chk("rdwr_keep", 16'hFF90, 8'h77, 3'b001);

        // reset on the edge ws2 would commit a write
        do_reset();
        wr_op(16'hFFA0, 8'h5A);
        A    = 16'hFFA0;
        D_in = 8'hC3;
        WR   = 1'b1;
        step();
        check("rstw_busy1", 16'(busy2), 16'h1);
        step();
        check("rstw_busy2", 16'(busy2), 16'h1);
        RESET = 1'b1;
        step();
        check("rstw_busy3", 16'(busy2), 16'h0);
        check("rstw_oe", 16'(doe2), 16'h0);
        RESET = 1'b0;
        WR    = 1'b0;
        step();
        check("rstw_idle", 16'(busy2), 16'h0);
        rd_chk("rstw_keep", 16'hFFA0, 8'h5A, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
